// File: rtl/cfg_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfg_rf_pkg
// Description : Shared constants for the configuration register file.
// Revision    : 1.0
// ============================================================================
package cfg_rf_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DEPTH  = 16;

    localparam int REG_OPA  = 0;
    localparam int REG_OPB  = 1;
    localparam int REG_UART = 2;
    localparam int REG_DIV  = 3;

    localparam logic [7:0] CFG_UART_RST = 8'h81;
    localparam logic [7:0] CFG_DIV_RST  = 8'd32;

    function automatic logic [7:0] reg_rst_val(input int idx);
        case (idx)
            REG_UART: return CFG_UART_RST;
            REG_DIV:  return CFG_DIV_RST;
            default:  return 8'h00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : cfg_reg_file
// Description : Bus-accessible configuration register file with error pulses.
// Revision    : 1.0
// ============================================================================
module cfg_reg_file
    import cfg_rf_pkg::*;
#(
    parameter int               DATA_W  = DEF_DATA_W,
    parameter int               ADDR_W  = DEF_ADDR_W,
    parameter int               DEPTH   = DEF_DEPTH,
    parameter logic [DEPTH-1:0] RO_MASK = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WrEn,
    input  logic              RdEn,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WrData,
    output logic [DATA_W-1:0] RdData,
    output logic              Rd_D_Vid,
    output logic              Err,
    output logic [DATA_W-1:0] oprand_A,
    output logic [DATA_W-1:0] oprand_B,
    output logic [DATA_W-1:0] uart_config,
    output logic [DATA_W-1:0] Div_ratio,
    output logic [1:0]        Cfg_Upd
);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_vld;
    logic              r_err;
    logic [1:0]        r_cfg_upd;

    logic [DEPTH-1:0]  w_sel;
    logic              w_in_range;
    logic              w_ro_hit;
    logic              w_coll;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_rng_err;
    logic              w_ro_err;
    logic [DATA_W-1:0] w_rd_val;

    // One-hot decode avoids indexing RO_MASK or the array with an out-of-range address.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_dec
            assign w_sel[gi] = (Address == ADDR_W'(gi));
        end
    endgenerate

    assign w_in_range = |w_sel;
    assign w_ro_hit   = |(w_sel & RO_MASK);

    assign w_coll    = WrEn & RdEn;
    assign w_wr_ok   = WrEn & ~RdEn & w_in_range & ~w_ro_hit;
    assign w_rd_ok   = RdEn & ~WrEn & w_in_range;
    assign w_rng_err = (WrEn ^ RdEn) & ~w_in_range;
    assign w_ro_err  = WrEn & ~RdEn & w_in_range & w_ro_hit;

    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel[i]) begin
                w_rd_val = r_regs[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= DATA_W'(reg_rst_val(i));
            end
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
            r_err     <= 1'b0;
            r_cfg_upd <= 2'b00;
        end else begin
            if (w_wr_ok) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_sel[i]) begin
                        r_regs[i] <= WrData;
                    end
                end
            end
            if (w_rd_ok) begin
                r_rd_data <= w_rd_val;
            end
            r_rd_vld  <= w_rd_ok;
            r_err     <= w_coll | w_rng_err | w_ro_err;
            // Pulses on every accepted write, even if the value is unchanged.
            r_cfg_upd <= {w_wr_ok & w_sel[REG_DIV], w_wr_ok & w_sel[REG_UART]};
        end
    end

    assign RdData      = r_rd_data;
    assign Rd_D_Vid    = r_rd_vld;
    assign Err         = r_err;
    assign Cfg_Upd     = r_cfg_upd;
    assign oprand_A    = r_regs[REG_OPA];
    assign oprand_B    = r_regs[REG_OPB];
    assign uart_config = r_regs[REG_UART];
    assign Div_ratio   = r_regs[REG_DIV];

endmodule
`default_nettype wire

// File: tb/tb_cfg_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfg_reg_file
// Description : Self-checking bench for cfg_reg_file (default, RO and short builds).
// Revision    : 1.0
// ============================================================================
module tb_cfg_reg_file;

    logic       CLK;
    logic       RST;
    logic       WrEn;
    logic       RdEn;
    logic [3:0] Address;
    logic [7:0] WrData;

    // Instance 0: defaults, 1: RO_MASK=16'h0002, 2: DEPTH=12
    logic [7:0] rd_data [3];
    logic       vld     [3];
    logic       err     [3];
    logic [7:0] opa     [3];
    logic [7:0] opb     [3];
    logic [7:0] uart    [3];
    logic [7:0] div     [3];
    logic [1:0] cfg     [3];

    int n_tests = 0;
    int n_fail  = 0;

    cfg_reg_file dut_def (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .RdData(rd_data[0]), .Rd_D_Vid(vld[0]), .Err(err[0]),
        .oprand_A(opa[0]), .oprand_B(opb[0]), .uart_config(uart[0]), .Div_ratio(div[0]),
        .Cfg_Upd(cfg[0])
    );

    cfg_reg_file #(.RO_MASK(16'h0002)) dut_ro (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .RdData(rd_data[1]), .Rd_D_Vid(vld[1]), .Err(err[1]),
        .oprand_A(opa[1]), .oprand_B(opb[1]), .uart_config(uart[1]), .Div_ratio(div[1]),
        .Cfg_Upd(cfg[1])
    );

    cfg_reg_file #(.DEPTH(12), .RO_MASK(12'h000)) dut_d12 (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .RdData(rd_data[2]), .Rd_D_Vid(vld[2]), .Err(err[2]),
        .oprand_A(opa[2]), .oprand_B(opb[2]), .uart_config(uart[2]), .Div_ratio(div[2]),
        .Cfg_Upd(cfg[2])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp_data;
    } rd_vec_t;

    // Reference model state
    logic [7:0]  m_regs [3][16];
    logic [7:0]  m_rd   [3];
    int          m_dep  [3];
    logic [15:0] m_ro   [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic access(input logic wr, input logic rd, input logic [3:0] a, input logic [7:0] d);
        @(negedge CLK);
        WrEn    = wr;
        RdEn    = rd;
        Address = a;
        WrData  = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0; WrEn = 1'b0; RdEn = 1'b0; Address = '0; WrData = '0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[k][i] = (i == 2) ? 8'h81 : (i == 3) ? 8'd32 : 8'h00;
            end
            m_rd[k] = 8'h00;
        end
    endtask

    rd_vec_t rst_tbl [16];

    initial begin
        RST = 1'b0; WrEn = 1'b0; RdEn = 1'b0; Address = '0; WrData = '0;
        m_dep = '{16, 16, 12};
        m_ro  = '{16'h0000, 16'h0002, 16'h0000};
        for (int i = 0; i < 16; i++) begin
            rst_tbl[i].addr     = 4'(i);
            rst_tbl[i].exp_data = (i == 2) ? 8'h81 : (i == 3) ? 8'h20 : 8'h00;
        end

        // Reset state while RST is held low
        #12;
        chk("rst_rddata", rd_data[0], 8'h00);
        chk("rst_vld",    vld[0],     1'b0);
        chk("rst_err",    err[0],     1'b0);
        chk("rst_cfgupd", cfg[0],     2'b00);
        chk("rst_uart",   uart[0],    8'h81);
        chk("rst_div",    div[0],     8'h20);
        do_reset();

        // Read every register back-to-back after reset
        for (int i = 0; i < 16; i++) begin
            access(1'b0, 1'b1, rst_tbl[i].addr, 8'h00);
            chk($sformatf("rst_read[%0d]", i), rd_data[0], rst_tbl[i].exp_data);
            chk($sformatf("rst_read_vld[%0d]", i), vld[0], 1'b1);
        end
        access(1'b0, 1'b0, 4'd0, 8'h00);
        chk("idle_vld", vld[0], 1'b0);

        // Write-then-read of the divider register
        access(1'b1, 1'b0, 4'd3, 8'h5A);
        chk("wr3_div",    div[0], 8'h5A);
        chk("wr3_cfgupd", cfg[0], 2'b10);
        chk("wr3_vld",    vld[0], 1'b0);
        access(1'b0, 1'b1, 4'd3, 8'h00);
        chk("rd3_data",   rd_data[0], 8'h5A);
        chk("rd3_vld",    vld[0], 1'b1);
        chk("rd3_cfgupd", cfg[0], 2'b00);

        // Collision
        access(1'b1, 1'b0, 4'd0, 8'h12);
        chk("wr0_opa", opa[0], 8'h12);
        access(1'b1, 1'b1, 4'd0, 8'hFF);
        chk("coll_opa",  opa[0],     8'h12);
        chk("coll_err",  err[0],     1'b1);
        chk("coll_vld",  vld[0],     1'b0);
        chk("coll_hold", rd_data[0], 8'h5A);
        access(1'b0, 1'b0, 4'd0, 8'h00);
        chk("coll_err_end", err[0], 1'b0);

        // Read-only register 1 in the RO build
        access(1'b1, 1'b0, 4'd1, 8'h33);
        chk("ro_opb",     opb[1], 8'h00);
        chk("ro_err",     err[1], 1'b1);
        chk("rw_opb",     opb[0], 8'h33);
        chk("rw_err",     err[0], 1'b0);
        access(1'b0, 1'b0, 4'd0, 8'h00);
        chk("ro_err_end", err[1], 1'b0);

        // Out of range in the DEPTH=12 build
        access(1'b1, 1'b0, 4'd5, 8'h3C);
        access(1'b0, 1'b1, 4'd5, 8'h00);
        chk("d12_rd5",      rd_data[2], 8'h3C);
        chk("d12_rd5_vld",  vld[2],     1'b1);
        access(1'b0, 1'b1, 4'd13, 8'h00);
        chk("d12_oor_err",  err[2],     1'b1);
        chk("d12_oor_vld",  vld[2],     1'b0);
        chk("d12_oor_hold", rd_data[2], 8'h3C);
        chk("def_rd13_vld", vld[0],     1'b1);
        access(1'b0, 1'b0, 4'd0, 8'h00);
        chk("d12_err_end",  err[2],     1'b0);

        // Reset asserted together with a write to register 2
        access(1'b1, 1'b0, 4'd2, 8'h44);
        chk("wr2_uart",   uart[0], 8'h44);
        chk("wr2_cfgupd", cfg[0],  2'b01);
        @(negedge CLK);
        WrEn = 1'b1; RdEn = 1'b0; Address = 4'd2; WrData = 8'h11;
        RST  = 1'b0;
        #1;
        chk("mid_rst_uart_async", uart[0], 8'h81);
        @(posedge CLK);
        #1;
        chk("mid_rst_uart",   uart[0], 8'h81);
        chk("mid_rst_cfgupd", cfg[0],  2'b00);
        @(negedge CLK);
        RST = 1'b1; WrEn = 1'b0;
        @(posedge CLK);
        #1;
        chk("post_rst_uart",   uart[0], 8'h81);
        chk("post_rst_cfgupd", cfg[0],  2'b00);
        chk("post_rst_err",    err[0],  1'b0);

        // First edge after release honours an access
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1; WrEn = 1'b1; RdEn = 1'b0; Address = 4'd3; WrData = 8'h09;
        @(posedge CLK);
        #1;
        chk("first_acc_div",    div[0], 8'h09);
        chk("first_acc_cfgupd", cfg[0], 2'b10);

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            int         r;
            logic       wr, rd;
            logic [3:0] a;
            logic [7:0] d;
            r  = int'($urandom_range(0, 9));
            wr = (r <= 4);
            rd = (r == 0) || (r >= 5 && r <= 8);
            a  = 4'($urandom_range(0, 15));
            d  = 8'($urandom);
            access(wr, rd, a, d);
            for (int k = 0; k < 3; k++) begin
                logic       e_err, e_vld;
                logic [1:0] e_cfg;
                logic       in_rng;
                in_rng = (int'(a) < m_dep[k]);
                e_err = 1'b0; e_vld = 1'b0; e_cfg = 2'b00;
                if (wr && rd) begin
                    e_err = 1'b1;
                end else if (wr) begin
                    if (!in_rng || m_ro[k][a]) begin
                        e_err = 1'b1;
                    end else begin
                        m_regs[k][a] = d;
                        if (a == 4'd2) e_cfg = 2'b01;
                        if (a == 4'd3) e_cfg = 2'b10;
                    end
                end else if (rd) begin
                    if (!in_rng) begin
                        e_err = 1'b1;
                    end else begin
                        m_rd[k] = m_regs[k][a];
                        e_vld   = 1'b1;
                    end
                end
                chk($sformatf("rnd%0d_rddata[%0d]", n, k), rd_data[k], m_rd[k]);
                chk($sformatf("rnd%0d_vld[%0d]", n, k),    vld[k],     e_vld);
                chk($sformatf("rnd%0d_err[%0d]", n, k),    err[k],     e_err);
                chk($sformatf("rnd%0d_cfg[%0d]", n, k),    cfg[k],     e_cfg);
                chk($sformatf("rnd%0d_opa[%0d]", n, k),    opa[k],     m_regs[k][0]);
                chk($sformatf("rnd%0d_opb[%0d]", n, k),    opb[k],     m_regs[k][1]);
                chk($sformatf("rnd%0d_uart[%0d]", n, k),   uart[k],    m_regs[k][2]);
                chk($sformatf("rnd%0d_div[%0d]", n, k),    div[k],     m_regs[k][3]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cfg_reg_file.md
CFG_REG_FILE -- requirements
Module: cfg_reg_file

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 8, register and data width in bits.
REQ-002 The block SHALL expose parameter ADDR_W, default 4, address width in bits.
REQ-003 The block SHALL expose parameter DEPTH, default 16, number of implemented registers, with DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL expose parameter RO_MASK, default 0, DEPTH bits; bit i set makes register i read-only to the bus.
REQ-005 The block SHALL have these ports:
- CLK  in  1  clock
- RST  in  1  asynchronous reset, active-low
- WrEn  in  1  write request
- RdEn  in  1  read request
- Address  in  ADDR_W  register index
- WrData  in  DATA_W  write data
- RdData  out  DATA_W  read data, registered
- Rd_D_Vid  out  1  read-data-valid pulse
- Err  out  1  access-error pulse
- oprand_A  out  DATA_W  register 0, continuous
- oprand_B  out  DATA_W  register 1, continuous
- uart_config  out  DATA_W  register 2, continuous
- Div_ratio  out  DATA_W  register 3, continuous
- Cfg_Upd  out  2  bit0 pulses on an accepted write to register 2; bit1 pulses on an accepted write to register 3

Function
REQ-006 A write SHALL be accepted when WrEn=1, RdEn=0, Address<DEPTH and RO_MASK[Address]=0; register[Address] takes WrData at that CLK edge.
REQ-007 A read SHALL be accepted when RdEn=1, WrEn=0 and Address<DEPTH.
- On the next edge, RdData takes register[Address] and Rd_D_Vid=1 for exactly one cycle.
- Latency is 1 cycle.
REQ-008 RdData SHALL hold its last value whenever no read is accepted.
REQ-009 Rd_D_Vid SHALL be 0 in every cycle that does not follow an accepted read.
REQ-010 WrEn=1 and RdEn=1 together SHALL be a collision:
- no register changes;
- RdData holds;
- Rd_D_Vid=0;
- Err pulses 1 for one cycle.
REQ-011 A read or write with Address>=DEPTH SHALL be ignored.
- Err pulses for one cycle.
- Rd_D_Vid stays 0.
REQ-012 A write to a register with its RO_MASK bit set SHALL be ignored.
- Err pulses for one cycle.
- The register keeps its value.
REQ-013 Cfg_Upd[0] or Cfg_Upd[1] SHALL pulse for one cycle, registered, in the cycle after an accepted write to register 2 or 3 respectively, even when the written value equals the old value.
REQ-014 Back-to-back accesses SHALL be accepted every cycle with no bubbles.
REQ-015 A read of an address written in the immediately preceding cycle SHALL return the new value.
REQ-016 The continuous outputs SHALL reflect a write in the cycle after the accepting edge.
REQ-017 WrEn=0 and RdEn=0 SHALL leave all state unchanged and all pulses at 0.

Reset
REQ-018 When RST=0, the block SHALL asynchronously set:
- register 2 to CFG_UART_RST (8'h81, zero-extended to DATA_W);
- register 3 to CFG_DIV_RST (32);
- all other registers to 0.
REQ-019 When RST=0, the block SHALL asynchronously set RdData, Rd_D_Vid, Err and Cfg_Upd to 0.
REQ-020 An access in progress at reset assertion SHALL be discarded, with no pulse after RST deasserts.
REQ-021 The first access SHALL be honoured on the first CLK edge after RST deasserts.

Structure
REQ-022 Package cfg_rf_pkg SHALL hold:
- register index constants REG_OPA=0, REG_OPB=1, REG_UART=2, REG_DIV=3;
- reset values CFG_UART_RST=8'h81, CFG_DIV_RST=8'd32;
- default DATA_W, ADDR_W and DEPTH.
REQ-023 The block SHALL be a single module with no sub-module.
REQ-024 The access-classification logic (write accepted, read accepted, collision, range error, read-only error) SHALL be combinational and feed one clocked process.

Verification
REQ-025 The bench SHALL cover reset: after RST release, read each register 0..15 -> RdData 0,0,0x81,0x20,0,...; Rd_D_Vid pulses once per read.
REQ-026 The bench SHALL cover write-then-read: write 0x5A to register 3, read register 3 on the next cycle -> RdData=0x5A with 1-cycle latency; Div_ratio=0x5A; Cfg_Upd=2'b10 pulse.
REQ-027 The bench SHALL cover collision: WrEn=RdEn=1, Address=0, WrData=0xFF -> oprand_A unchanged; Err=1 for one cycle; Rd_D_Vid=0.
REQ-028 The bench SHALL cover read-only protection: build with RO_MASK=16'h0002, write 0x33 to register 1 -> oprand_B stays 0; Err pulses.
REQ-029 The bench SHALL cover out of range: build with DEPTH=12, read Address=13 -> Err pulses; Rd_D_Vid=0; RdData holds its previous value.
REQ-030 The bench SHALL cover reset mid-operation: assert RST in the same cycle as a write of 0x11 to register 2 -> uart_config=0x81; Cfg_Upd stays 0 after release.
